// File: rtl/axi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_ram_pkg
// Description : Shared definitions for the AXI4-Lite RAM controller:
//               response codes, controller FSM state encoding and the
//               direction served last by the read/write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_ram_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BRESP = 2'd1,
      ST_RCAP  = 2'd2,
      ST_RRESP = 2'd3
   } state_t;

   typedef enum logic {
      DIR_READ  = 1'b0,
      DIR_WRITE = 1'b1
   } dir_t;

endpackage
`default_nettype wire

// File: rtl/axi_lite_wr_collector.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_wr_collector
// Description : Captures the AXI4-Lite AW and W channels independently into
//               holding registers. A write becomes pending once both halves
//               are held; the controller clears both with i_consume.
// Ports       : clk, rst            - clock / synchronous active-high reset
//               i_aw* / o_awready   - write address channel
//               i_w*  / o_wready    - write data channel
//               i_consume           - controller has issued the held write
//               o_wr_pending        - both address and data are held
//               o_awaddr/o_wdata/o_wstrb - held write fields
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_wr_collector
   import axi_ram_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH_BYTES = 4,
   localparam int DATA_WIDTH_BITS = DATA_WIDTH_BYTES * 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ADDR_WIDTH-1:0]   i_awaddr,
   input  logic                        i_awvalid,
   output logic                        o_awready,
   input  logic [DATA_WIDTH_BITS-1:0]  i_wdata,
   input  logic [DATA_WIDTH_BYTES-1:0] i_wstrb,
   input  logic                        i_wvalid,
   output logic                        o_wready,
   input  logic                        i_consume,
   output logic                        o_wr_pending,
   output logic [AXI_ADDR_WIDTH-1:0]   o_awaddr,
   output logic [DATA_WIDTH_BITS-1:0]  o_wdata,
   output logic [DATA_WIDTH_BYTES-1:0] o_wstrb
);

   logic                        r_aw_held;
   logic                        r_w_held;
   logic [AXI_ADDR_WIDTH-1:0]   r_awaddr;
   logic [DATA_WIDTH_BITS-1:0]  r_wdata;
   logic [DATA_WIDTH_BYTES-1:0] r_wstrb;

   // Readies drop during reset so nothing is captured while the flags clear.
   assign o_awready    = !r_aw_held && !rst;
   assign o_wready     = !r_w_held  && !rst;
   assign o_wr_pending = r_aw_held && r_w_held;
   assign o_awaddr     = r_awaddr;
   assign o_wdata      = r_wdata;
   assign o_wstrb      = r_wstrb;

   // Consume and capture never collide: consume requires both flags set,
   // which holds both readies low in that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
      end else begin
         if (i_consume) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (i_awvalid && o_awready) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= i_awaddr;
         end
         if (i_wvalid && o_wready) begin
            r_w_held <= 1'b1;
            r_wdata  <= i_wdata;
            r_wstrb  <= i_wstrb;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/axi_lite_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_ram_ctrl
// Description : AXI4-Lite slave sequencing a RAM with one read port and one
//               byte-strobed write port. Pending writes and reads are served
//               alternately on conflict; out-of-range slots get SLVERR and
//               never touch the RAM.
// Ports       : clk, rst          - clock / synchronous active-high reset
//               s_axi_aw*/w*/b*   - AXI4-Lite write channels
//               s_axi_ar*/r*      - AXI4-Lite read channels
//               r_en/r_addr/r_data         - RAM read port (1-cycle latency)
//               w_en/w_addr/w_data/w_strb  - RAM write port
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_ram_ctrl
   import axi_ram_pkg::*;
#(
   parameter int NUM_SLOTS        = 5,
   parameter int DATA_WIDTH_BYTES = 4,
   parameter int AXI_ADDR_WIDTH   = 32,
   localparam int DATA_WIDTH_BITS = DATA_WIDTH_BYTES * 8,
   localparam int ADDR_WIDTH_BITS = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
   localparam int BYTE_OFF        = $clog2(DATA_WIDTH_BYTES)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                        s_axi_awvalid,
   output logic                        s_axi_awready,
   input  logic [DATA_WIDTH_BITS-1:0]  s_axi_wdata,
   input  logic [DATA_WIDTH_BYTES-1:0] s_axi_wstrb,
   input  logic                        s_axi_wvalid,
   output logic                        s_axi_wready,
   output logic [1:0]                  s_axi_bresp,
   output logic                        s_axi_bvalid,
   input  logic                        s_axi_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                        s_axi_arvalid,
   output logic                        s_axi_arready,
   output logic [DATA_WIDTH_BITS-1:0]  s_axi_rdata,
   output logic [1:0]                  s_axi_rresp,
   output logic                        s_axi_rvalid,
   input  logic                        s_axi_rready,
   output logic                        r_en,
   output logic [ADDR_WIDTH_BITS-1:0]  r_addr,
   input  logic [DATA_WIDTH_BITS-1:0]  r_data,
   output logic                        w_en,
   output logic [ADDR_WIDTH_BITS-1:0]  w_addr,
   output logic [DATA_WIDTH_BITS-1:0]  w_data,
   output logic [DATA_WIDTH_BYTES-1:0] w_strb
);

   state_t                       r_state;
   state_t                       w_state_nxt;
   dir_t                         r_last;
   logic [1:0]                   r_bresp;
   logic [1:0]                   r_rresp;
   logic                         r_rd_ok;
   logic [DATA_WIDTH_BITS-1:0]   r_rdata;

   logic                         w_wr_pending;
   logic [AXI_ADDR_WIDTH-1:0]    w_held_awaddr;
   logic [AXI_ADDR_WIDTH-1:0]    w_aw_slot;
   logic [AXI_ADDR_WIDTH-1:0]    w_ar_slot;
   logic                         w_aw_inrange;
   logic                         w_ar_inrange;
   logic                         w_sel_write;
   logic                         w_sel_read;

   axi_lite_wr_collector #(
      .AXI_ADDR_WIDTH   (AXI_ADDR_WIDTH),
      .DATA_WIDTH_BYTES (DATA_WIDTH_BYTES)
   ) u_wr_collector (
      .clk          (clk),
      .rst          (rst),
      .i_awaddr     (s_axi_awaddr),
      .i_awvalid    (s_axi_awvalid),
      .o_awready    (s_axi_awready),
      .i_wdata      (s_axi_wdata),
      .i_wstrb      (s_axi_wstrb),
      .i_wvalid     (s_axi_wvalid),
      .o_wready     (s_axi_wready),
      .i_consume    (w_sel_write),
      .o_wr_pending (w_wr_pending),
      .o_awaddr     (w_held_awaddr),
      .o_wdata      (w_data),
      .o_wstrb      (w_strb)
   );

   // Slot index keeps the full address width so high address bits
   // participate in the range check instead of aliasing onto low slots.
   assign w_aw_slot    = w_held_awaddr >> BYTE_OFF;
   assign w_ar_slot    = s_axi_araddr >> BYTE_OFF;
   assign w_aw_inrange = w_aw_slot < AXI_ADDR_WIDTH'(NUM_SLOTS);
   assign w_ar_inrange = w_ar_slot < AXI_ADDR_WIDTH'(NUM_SLOTS);

   assign w_addr        = w_aw_slot[ADDR_WIDTH_BITS-1:0];
   assign r_addr        = w_ar_slot[ADDR_WIDTH_BITS-1:0];
   assign w_en          = w_sel_write && w_aw_inrange;
   assign r_en          = w_sel_read && w_ar_inrange;
   assign s_axi_arready = w_sel_read;
   assign s_axi_bvalid  = (r_state == ST_BRESP);
   assign s_axi_rvalid  = (r_state == ST_RRESP);
   assign s_axi_bresp   = r_bresp;
   assign s_axi_rresp   = r_rresp;
   assign s_axi_rdata   = r_rdata;

   always_comb begin
      w_state_nxt = r_state;
      w_sel_write = 1'b0;
      w_sel_read  = 1'b0;
      // On a tie the direction not served last wins.
      if (!rst && r_state == ST_IDLE) begin
         if (w_wr_pending && (!s_axi_arvalid || r_last == DIR_READ)) begin
            w_sel_write = 1'b1;
         end else if (s_axi_arvalid) begin
            w_sel_read = 1'b1;
         end
      end
      case (r_state)
         ST_IDLE: begin
            if (w_sel_write) begin
               w_state_nxt = ST_BRESP;
            end else if (w_sel_read) begin
               w_state_nxt = ST_RCAP;
            end
         end
         ST_BRESP: if (s_axi_bready) w_state_nxt = ST_IDLE;
         ST_RCAP:  w_state_nxt = ST_RRESP;
         ST_RRESP: if (s_axi_rready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_last  <= DIR_READ;
         r_bresp <= RESP_OKAY;
         r_rresp <= RESP_OKAY;
         r_rd_ok <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_sel_write) begin
            r_bresp <= w_aw_inrange ? RESP_OKAY : RESP_SLVERR;
            r_last  <= DIR_WRITE;
         end
         if (w_sel_read) begin
            r_rresp <= w_ar_inrange ? RESP_OKAY : RESP_SLVERR;
            r_rd_ok <= w_ar_inrange;
            r_last  <= DIR_READ;
         end
         // RAM data is only meaningful if a read was actually issued.
         if (r_state == ST_RCAP) begin
            r_rdata <= r_rd_ok ? r_data : '0;
         end
      end
   end

endmodule
`default_nettype wire
